// File: rtl/exibe_sequencia.sv
// Sequence playback stage: reads RAM words 0..rodada in order, lights each one-hot word for
// T_ACESO cycles followed by a T_APAGADO dark gap, then pulses pronto for one cycle.
module exibe_sequencia #(
  parameter int unsigned T_INICIAL = 500,
  parameter int unsigned T_ACESO   = 1000,
  parameter int unsigned T_APAGADO = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] rodada,
  input  logic [3:0] dado,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic       db_invalido,
  output logic [2:0] db_estado
);

  // One shared down-counter covers every timed phase, so it is sized for the longest one.
  localparam int unsigned TMax =
      (T_INICIAL > T_ACESO) ? ((T_INICIAL > T_APAGADO) ? T_INICIAL : T_APAGADO)
                            : ((T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO);
  localparam int unsigned CntW = $clog2(TMax) + 1;

  localparam logic [CntW-1:0] CntInicial = CntW'(T_INICIAL - 1);
  localparam logic [CntW-1:0] CntAceso   = CntW'(T_ACESO - 1);
  localparam logic [CntW-1:0] CntApagado = CntW'(T_APAGADO - 1);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StEspera = 3'd1,
    StMostra = 3'd2,
    StApaga  = 3'd3,
    StFim    = 3'd4
  } estado_e;

  estado_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      end_q, end_d;
  logic [3:0]      rod_q, rod_d;

  logic cnt_zero;
  logic dado_one_hot;

  assign cnt_zero     = (cnt_q == '0);
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign dado_one_hot = (dado != 4'd0) && ((dado & (dado - 4'd1)) == 4'd0);

  // State, counter, address and latched round registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      end_q   <= 4'd0;
      rod_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      end_q   <= end_d;
      rod_q   <= rod_d;
    end
  end

  // Next-state logic and Moore outputs; leds/db_invalido follow dado only while showing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    end_d       = end_q;
    rod_d       = rod_q;
    leds        = 4'd0;
    ocupado     = 1'b0;
    pronto      = 1'b0;
    db_invalido = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (iniciar) begin
          rod_d   = rodada;
          end_d   = 4'd0;
          cnt_d   = CntInicial;
          state_d = StEspera;
        end
      end

      StEspera: begin
        ocupado = 1'b1;
        if (cnt_zero) begin
          cnt_d   = CntAceso;
          state_d = StMostra;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end

      StMostra: begin
        ocupado     = 1'b1;
        leds        = dado;
        db_invalido = ~dado_one_hot;
        if (cnt_zero) begin
          cnt_d   = CntApagado;
          state_d = StApaga;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end

      StApaga: begin
        ocupado = 1'b1;
        if (cnt_zero) begin
          // Stopping on the latched last address means endereco never wraps.
          if (end_q == rod_q) begin
            state_d = StFim;
          end else begin
            end_d   = end_q + 4'd1;
            cnt_d   = CntAceso;
            state_d = StMostra;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end

      StFim: begin
        pronto  = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign endereco  = end_q;
  assign db_estado = state_q;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Self-checking bench for exibe_sequencia: a timeline model derives every output from the
// cycle count since the start edge, plus hand-computed checks at specific cycles.
module tb_exibe_sequencia;

  localparam int TI  = 2;
  localparam int TA  = 4;
  localparam int TP  = 3;
  localparam int PER = TA + TP;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic [3:0] rodada = 4'd0;
  logic [3:0] dado;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       ocupado;
  logic       pronto;
  logic       db_invalido;
  logic [2:0] db_estado;

  logic [3:0] ram [16];
  assign dado = ram[endereco];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  exibe_sequencia #(
    .T_INICIAL(TI),
    .T_ACESO  (TA),
    .T_APAGADO(TP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .iniciar    (iniciar),
    .rodada     (rodada),
    .dado       (dado),
    .endereco   (endereco),
    .leds       (leds),
    .ocupado    (ocupado),
    .pronto     (pronto),
    .db_invalido(db_invalido),
    .db_estado  (db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Timeline model: run active for m_t cycles since the start edge, then a single FIM cycle.
  logic       m_act = 1'b0;
  logic       m_fim = 1'b0;
  int         m_t   = 0;
  logic [3:0] m_rod = 4'd0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_act <= 1'b0;
      m_fim <= 1'b0;
      m_t   <= 0;
      m_rod <= 4'd0;
    end else if (m_act) begin
      if (m_t + 1 == TI + (int'(m_rod) + 1) * PER) begin
        m_act <= 1'b0;
        m_fim <= 1'b1;
      end else begin
        m_t <= m_t + 1;
      end
    end else if (m_fim) begin
      m_fim <= 1'b0;
    end else if (iniciar) begin
      m_act <= 1'b1;
      m_t   <= 0;
      m_rod <= rodada;
    end
  end

  logic [3:0] e_leds, e_addr;
  logic [2:0] e_st;
  logic       e_ocu, e_pr, e_inv;
  int         tp, k;

  always @(negedge clock) begin
    e_leds = 4'd0;
    e_addr = m_rod;
    e_st   = 3'd0;
    e_ocu  = 1'b0;
    e_pr   = 1'b0;
    e_inv  = 1'b0;
    if (reset) begin
      e_addr = 4'd0;
    end else if (m_fim) begin
      e_pr = 1'b1;
      e_st = 3'd4;
    end else if (m_act) begin
      e_ocu = 1'b1;
      if (m_t < TI) begin
        e_st   = 3'd1;
        e_addr = 4'd0;
      end else begin
        tp     = m_t - TI;
        k      = tp / PER;
        e_addr = 4'(k);
        if (tp % PER < TA) begin
          e_st   = 3'd2;
          e_leds = ram[k];
          e_inv  = ($countones(ram[k]) != 1);
        end else begin
          e_st = 3'd3;
        end
      end
    end
    chk("model_leds", leds, e_leds);
    chk("model_endereco", endereco, e_addr);
    chk("model_estado", {1'b0, db_estado}, {1'b0, e_st});
    chk("model_ocupado", {3'd0, ocupado}, {3'd0, e_ocu});
    chk("model_pronto", {3'd0, pronto}, {3'd0, e_pr});
    chk("model_invalido", {3'd0, db_invalido}, {3'd0, e_inv});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulse iniciar for one edge (e0); afterwards the bench sits in cycle e0.
  task automatic start(input logic [3:0] r);
    rodada  = r;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    cyc     = 0;
  endtask

  // Move to the middle of cycle e0+c.
  task automatic at(input int c);
    repeat (c - cyc) @(posedge clock);
    cyc = c;
    #3;
  endtask

  task automatic ram_default();
    for (int i = 0; i < 16; i++) ram[i] = 4'b0001 << (i % 4);
  endtask

  int pr_seen;

  initial begin
    ram_default();
    #2 reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Idle after reset
    repeat (10) tick();
    #3;
    chk("t1_estado", {1'b0, db_estado}, 4'd0);
    chk("t1_ocupado", {3'd0, ocupado}, 4'd0);
    chk("t1_leds", leds, 4'd0);
    tick();

    // Single-word playback
    start(4'd0);
    at(0);  chk("t2_ocupado_e0", {3'd0, ocupado}, 4'd1);
    at(1);  chk("t2_leds_dark_e1", leds, 4'd0);
    at(2);  chk("t2_leds_e2", leds, 4'b0001);
    at(5);  chk("t2_leds_e5", leds, 4'b0001);
    at(6);  chk("t2_leds_e6", leds, 4'd0);
    at(8);  chk("t2_pronto_e8", {3'd0, pronto}, 4'd0);
    at(9);  chk("t2_pronto_e9", {3'd0, pronto}, 4'd1);
    chk("t2_ocupado_e9", {3'd0, ocupado}, 4'd0);
    at(10); chk("t2_pronto_e10", {3'd0, pronto}, 4'd0);
    tick();

    // Four words
    start(4'd3);
    at(9);  chk("t3_leds_w1", leds, 4'b0010);
    at(16); chk("t3_leds_w2", leds, 4'b0100);
    at(23); chk("t3_leds_w3", leds, 4'b1000);
    chk("t3_endereco_w3", endereco, 4'd3);
    at(29); chk("t3_pronto_e29", {3'd0, pronto}, 4'd0);
    at(30); chk("t3_pronto_e30", {3'd0, pronto}, 4'd1);
    chk("t3_endereco_fim", endereco, 4'd3);
    at(32);
    tick();

    // Full 16-word playback with iniciar held for 5 edges
    rodada  = 4'd15;
    iniciar = 1'b1;
    repeat (5) tick();
    iniciar = 1'b0;
    cyc     = 4;
    at(107); chk("t4_endereco_last", endereco, 4'd15);
    at(113); chk("t4_pronto_e113", {3'd0, pronto}, 4'd0);
    at(114); chk("t4_pronto_e114", {3'd0, pronto}, 4'd1);
    at(130); chk("t4_no_restart", {3'd0, ocupado}, 4'd0);
    tick();

    // Reset mid-playback
    start(4'd3);
    at(12);
    reset = 1'b1;
    #1;
    chk("t5_leds_rst", leds, 4'd0);
    chk("t5_ocupado_rst", {3'd0, ocupado}, 4'd0);
    chk("t5_estado_rst", {1'b0, db_estado}, 4'd0);
    tick();
    reset   = 1'b0;
    pr_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (pronto === 1'b1) pr_seen++;
    end
    chk("t5_no_pronto", 4'(pr_seen), 4'd0);
    start(4'd0);
    at(0);  chk("t5_restart_addr", endereco, 4'd0);
    at(2);  chk("t5_restart_leds", leds, 4'b0001);
    at(11);
    tick();

    // Non-one-hot word at address 1
    ram[1] = 4'b0011;
    start(4'd1);
    at(2);  chk("t6_inv_w0", {3'd0, db_invalido}, 4'd0);
    at(9);  chk("t6_inv_w1", {3'd0, db_invalido}, 4'd1);
    chk("t6_leds_w1", leds, 4'b0011);
    at(12); chk("t6_inv_w1_end", {3'd0, db_invalido}, 4'd1);
    at(13); chk("t6_inv_dark", {3'd0, db_invalido}, 4'd0);
    at(16); chk("t6_pronto", {3'd0, pronto}, 4'd1);
    at(18);
    tick();
    ram_default();

    // Random stimulus against the model
    for (int i = 0; i < 16; i++) ram[i] = 4'($urandom);
    for (int i = 0; i < 3000; i++) begin
      iniciar = ($urandom % 8) == 0;
      rodada  = 4'($urandom);
      reset   = ($urandom % 400) == 0;
      tick();
    end
    reset   = 1'b0;
    iniciar = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exibe_sequencia.md
Name: exibe_sequencia

Overview:
- Playback stage directly downstream of the game's sequence RAM. It drives the `leds` output of the memory game.
- On a start request it reads RAM addresses 0..rodada in order. Each stored one-hot word is lit for a fixed time, followed by a dark gap.
- It then pulses `pronto` so the game controller can enable player input.
- The controller's "mostra jogada" phase is replaced by this block.

Parameters:
- T_INICIAL, 500, cycles of dark lead-in before the first word (≥1)
- T_ACESO, 1000, cycles each word is lit (≥1)
- T_APAGADO, 500, cycles of dark gap after each word (≥1)
- Single internal down-counter sized to $clog2(max(T_INICIAL, T_ACESO, T_APAGADO))+1.

Ports:
- clock  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high; forces idle state
- iniciar  in  1  start request, level-sampled in IDLE only
- rodada  in  4  last address to show (0..15), latched at start
- dado  in  4  RAM read data, combinational w.r.t. endereco
- endereco  out  4  RAM read address
- leds  out  4  LED drive
- ocupado  out  1  high while playback in progress
- pronto  out  1  one-cycle pulse at end of playback
- db_invalido  out  1  high while lit word is not one-hot
- db_estado  out  3  state code

Behaviour:
- Reset (async, any state): state=IDLE, endereco=0, rodada latch=0, counter=0. Outputs leds=0000, ocupado=0, pronto=0, db_invalido=0.
- State codes:
  - IDLE=0
  - ESPERA=1
  - MOSTRA=2
  - APAGA=3
  - FIM=4
  - others unused; any unused code goes to IDLE next cycle.
- IDLE:
  - leds=0, ocupado=0.
  - If iniciar=1 at a rising edge (edge e0): latch rodada, endereco←0, counter←T_INICIAL-1, go to ESPERA.
- ESPERA:
  - ocupado=1, leds=0.
  - Counter decrements each cycle; at 0, reload T_ACESO-1 and go to MOSTRA.
  - Duration is exactly T_INICIAL cycles.
- MOSTRA:
  - ocupado=1, leds=dado (combinational from current endereco).
  - db_invalido=1 if dado is not exactly one-hot (including 0000). The word is still displayed as-is.
  - Lasts exactly T_ACESO cycles, then counter←T_APAGADO-1 and go to APAGA.
- APAGA:
  - ocupado=1, leds=0.
  - Lasts exactly T_APAGADO cycles.
  - At end, if endereco==latched rodada: go to FIM, endereco unchanged.
  - Otherwise endereco←endereco+1 and go to MOSTRA, counter←T_ACESO-1.
- FIM:
  - One cycle only: pronto=1, ocupado=0, leds=0, then IDLE.
- Overall latency: FIM is entered at edge e0 + T_INICIAL + (rodada+1)·(T_ACESO+T_APAGADO). pronto is high for exactly the following clock cycle.
- Address wrap: endereco never exceeds latched rodada. rodada=15 shows all 16 words, and endereco does not wrap to 0 during playback.
- iniciar while ocupado=1 or in FIM is ignored. No queuing, no restart.
- iniciar held continuously high: after FIM→IDLE, a new playback starts on the next edge (one IDLE cycle between runs).
- Changes on rodada after e0 have no effect until the next start.
- Reset mid-playback: immediate return to IDLE outputs. No pronto is generated for the aborted run.
- All outputs except leds/db_invalido in MOSTRA are registered-state decodes (Moore). leds follows dado combinationally in MOSTRA only.

Test Plan:
All tests use T_INICIAL=2, T_ACESO=4, T_APAGADO=3. RAM model: addr0=0001, addr1=0010, addr2=0100, addr3=1000, rest repeat.
1. Reset pulse, then idle 10 cycles → leds=0000, ocupado=0, pronto=0, db_estado=0 throughout.
2. rodada=0, iniciar 1 cycle at e0 → ocupado=1 from e0. leds=0001 for cycles e0+2..e0+5, then 0000 for e0+6..e0+8. pronto high in cycle e0+9 only, ocupado=0 then.
3. rodada=3 → leds shows 0001, 0010, 0100, 1000, each 4 cycles with 3 dark cycles between. endereco steps 0→3 with no wrap. pronto at e0+30.
4. rodada=15 with iniciar held high 5 cycles → full 16-word playback, pronto at e0+114. Extra iniciar cycles are ignored. After pronto, no restart once iniciar is low.
5. Reset asserted at e0+12 of a rodada=3 run → same-cycle async: leds=0, ocupado=0, db_estado=0. No pronto ever appears. New iniciar restarts from endereco 0.
6. RAM addr1 forced to 0011, rodada=1 → db_invalido=1 exactly during the 4 MOSTRA cycles of addr1 while leds=0011. db_invalido=0 elsewhere.
